counter_snapshot_reader: RTL
============================

Name: counter_snapshot_reader

Overview:
- Sits directly downstream of the three 20-bit event counters: instruction count, memory access and memory correction.
- On a snapshot request, captures all three counts in the same cycle, then streams them out one word at a time over a valid/ready interface to the debug/host readout path.
- Optionally issues a one-cycle clear pulse back to the counters once the readout completes.

Parameters:
- CNT_W, 20, width of each incoming count.
- DATA_W, 32, output word width; must be >= CNT_W; counts are zero-extended to this width.
- CLEAR_ON_READ, 0, when 1 a `cnt_clr` pulse is issued after the last word is accepted.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  reset; asynchronous, active-low (asserted at 0).
- inst_count  in  CNT_W  instruction count value.
- ma_count  in  CNT_W  memory access count value.
- mc_count  in  CNT_W  memory correction count value.
- snap_req  in  1  single-cycle snapshot request.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word when out_valid & out_ready.
- out_data  out  DATA_W  zero-extended count or sequence word.
- out_id  out  2  word index: 0=IC, 1=MA, 2=MC, 3=SEQ.
- out_last  out  1  high on the final word of a snapshot.
- busy  out  1  high in any state other than IDLE.
- cnt_clr  out  1  one-cycle active-high clear to the counters.

Behaviour:
- Reset values: state=IDLE; out_valid, out_data, out_id, out_last, busy, cnt_clr and pending all 0; snapshot registers 0.
- States: IDLE, SEND, CLEAR.
- IDLE:
  - If snap_req or pending is high at posedge N, latch all three counts into snapshot registers, clear pending, set word index=0 and go to SEND.
  - out_valid rises in cycle N+1. Latency from request to first valid is 1 cycle.
- SEND:
  - out_valid=1; out_data/out_id are driven from the snapshot registers by index.
  - Data and id must stay stable while out_valid & !out_ready.
  - On acceptance, index increments. out_last=1 when index is the final word.
  - Acceptance of the final word: go to CLEAR if CLEAR_ON_READ=1, else IDLE. out_valid drops the next cycle.
  - Back-to-back acceptance is allowed; with out_ready held high, one word transfers per cycle (3 cycles for 3 words).
- CLEAR: cnt_clr=1 for exactly one cycle, then IDLE.
- snap_req while busy: sets the one-deep pending flag. Further requests while pending is set are dropped, not counted.
  - A pending request starts a new snapshot on the first IDLE cycle. The IDLE cycle between snapshots is mandatory.
- snap_req arriving in the same cycle that the final word is accepted: sets pending and is served after IDLE.
- Snapshot isolation: counts changing after capture never affect words in flight.
- Counter wrap (0xFFFFF to 0) is transparent; the value is reported as captured.
- Reset mid-transfer: returns to IDLE immediately; out_valid=0, pending discarded, no cnt_clr issued.
- busy = (state != IDLE).

Optional Feature:
- Macro: COUNTER_SNAPSHOT_SEQ_EN.
- Defined:
  - A 16-bit snapshot sequence counter increments on each capture, wrapping 0xFFFF to 0.
  - The first snapshot after reset reports 1.
  - A 4th word (out_id=3, seq zero-extended) is appended; out_last moves to word 3.
- Undefined: 3 words only, no sequence register; out_id never equals 3.

Decomposition:
- Shared package counter_snapshot_pkg:
  - state enum {IDLE, SEND, CLEAR}
  - word-id constants ID_IC=0, ID_MA=1, ID_MC=2, ID_SEQ=3
  - NUM_WORDS (3, or 4 with the macro)
  - SEQ_W=16
- One natural sub-module, snapshot_word_mux: purely combinational; selects and zero-extends the snapshot register by index. The FSM stays in the top level.

Test Plan:
- Reset, then inst=5, ma=9, mc=2, snap_req pulse, out_ready held 1 -> out_valid from the next cycle; words (0,5), (1,9), (2,2) on 3 consecutive cycles; out_last only on id 2; busy falls after.
- Backpressure: out_ready=0 for 4 cycles on word 1 -> out_data=9, out_id=1 held stable; counts changed during the stall still report captured values.
- Two snap_req pulses during SEND, then a third -> exactly one extra snapshot after one IDLE cycle; the third request is dropped.
- CLEAR_ON_READ=1 -> cnt_clr high exactly one cycle after the final acceptance; a wrapped value 0xFFFFF is reported as 0x000FFFFF.
- Reset asserted low mid-word-1 -> out_valid=0 asynchronously; after release, no words, no cnt_clr and busy=0 until a new snap_req.
- With COUNTER_SNAPSHOT_SEQ_EN, two snapshots -> 4th word id=3 with data 1, then 2; out_last on id 3.

Source files
------------

// File: rtl/counter_snapshot_pkg.sv
// counter_snapshot_pkg: shared state, word ids and sizes for the snapshot reader
// Macro COUNTER_SNAPSHOT_SEQ_EN adds the sequence word (4 words instead of 3).
package counter_snapshot_pkg;
  typedef enum logic [1:0] {IDLE, SEND, CLEAR} state_t;
  localparam logic [1:0] ID_IC = 2'd0;
  localparam logic [1:0] ID_MA = 2'd1;
  localparam logic [1:0] ID_MC = 2'd2;
  localparam logic [1:0] ID_SEQ = 2'd3;
  localparam int SEQ_W = 16;
`ifdef COUNTER_SNAPSHOT_SEQ_EN
  localparam int NUM_WORDS = 4;
`else
  localparam int NUM_WORDS = 3;
`endif
  localparam logic [1:0] LAST_ID = 2'(NUM_WORDS - 1);
endpackage

// File: rtl/snapshot_word_mux.sv
// snapshot_word_mux: selects one snapshot value by word index and zero-extends it
// Ports: idx (word id), ic/ma/mc (captured counts), seq (sequence value), data (selected word).
module snapshot_word_mux
  import counter_snapshot_pkg::*;
#(
  parameter int CNT_W = 20,
  parameter int DATA_W = 32
) (
  input  logic [1:0]        idx,
  input  logic [CNT_W-1:0]  ic,
  input  logic [CNT_W-1:0]  ma,
  input  logic [CNT_W-1:0]  mc,
  input  logic [SEQ_W-1:0]  seq,
  output logic [DATA_W-1:0] data
);
  assign data = idx == ID_IC ? DATA_W'(ic) :
                idx == ID_MA ? DATA_W'(ma) :
                idx == ID_MC ? DATA_W'(mc) : DATA_W'(seq);
endmodule

// File: rtl/counter_snapshot_reader.sv
// counter_snapshot_reader: captures three event counts on request and streams them over valid/ready
// Ports: clk, rst (async active-low), inst_count/ma_count/mc_count, snap_req,
//   out_valid/out_ready/out_data/out_id/out_last stream, busy, cnt_clr.
// Macro COUNTER_SNAPSHOT_SEQ_EN appends a 16-bit snapshot sequence word (id 3).
module counter_snapshot_reader
  import counter_snapshot_pkg::*;
#(
  parameter int CNT_W = 20,
  parameter int DATA_W = 32,
  parameter int CLEAR_ON_READ = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  inst_count,
  input  logic [CNT_W-1:0]  ma_count,
  input  logic [CNT_W-1:0]  mc_count,
  input  logic              snap_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_id,
  output logic              out_last,
  output logic              busy,
  output logic              cnt_clr
);
  state_t state;
  logic pending, cap, accept;
  logic [CNT_W-1:0] ic_q, ma_q, mc_q;
  logic [SEQ_W-1:0] seq_nxt;
  logic [1:0] nidx;
  logic [DATA_W-1:0] word;
  assign cap = state == IDLE && (snap_req || pending);
  assign accept = out_valid && out_ready;
  // Next word is selected ahead of time so out_data/out_id can be registered;
  // on capture the mux sees the live counts that are being latched this edge.
  assign nidx = cap ? ID_IC : out_id + 2'd1;
`ifdef COUNTER_SNAPSHOT_SEQ_EN
  logic [SEQ_W-1:0] seq_q;
  assign seq_nxt = cap ? seq_q + 1'b1 : seq_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) seq_q <= '0;
    else if (cap) seq_q <= seq_q + 1'b1;
`else
  assign seq_nxt = '0;
`endif
  snapshot_word_mux #(.CNT_W(CNT_W), .DATA_W(DATA_W)) u_mux (
    .idx  (nidx),
    .ic   (cap ? inst_count : ic_q),
    .ma   (cap ? ma_count : ma_q),
    .mc   (cap ? mc_count : mc_q),
    .seq  (seq_nxt),
    .data (word)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pending <= 1'b0;
      ic_q <= '0;
      ma_q <= '0;
      mc_q <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_id <= '0;
      out_last <= 1'b0;
      busy <= 1'b0;
      cnt_clr <= 1'b0;
    end else begin
      cnt_clr <= 1'b0;
      // One-deep: a request while busy is remembered once, extra ones are lost.
      if (snap_req && state != IDLE) pending <= 1'b1;
      case (state)
        IDLE: if (cap) begin
          ic_q <= inst_count;
          ma_q <= ma_count;
          mc_q <= mc_count;
          pending <= 1'b0;
          out_valid <= 1'b1;
          out_id <= nidx;
          out_data <= word;
          out_last <= nidx == LAST_ID;
          busy <= 1'b1;
          state <= SEND;
        end
        SEND: if (accept) begin
          if (out_last) begin
            out_valid <= 1'b0;
            out_last <= 1'b0;
            cnt_clr <= CLEAR_ON_READ != 0;
            busy <= CLEAR_ON_READ != 0;
            state <= CLEAR_ON_READ != 0 ? CLEAR : IDLE;
          end else begin
            out_id <= nidx;
            out_data <= word;
            out_last <= nidx == LAST_ID;
          end
        end
        default: begin
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
